// File: rtl/xor_diff_accum.sv
`default_nettype none
// ============================================================================
// Module   : xor_diff_accum
// Brief    : Frame statistics (Hamming distance, OR-mask, all-equal) over XOR diff words
// Revision : 1.0
// ============================================================================
module xor_diff_accum #(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] diff,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] distance,
  output logic [WIDTH-1:0] or_mask,
  output logic             equal
);

  localparam int CNT_BITS = $clog2(FRAME_LEN + 1);
  localparam int POP_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_BITS-1:0] C_LAST_IDX = CNT_BITS'(FRAME_LEN - 1);
  localparam logic [CNT_BITS-1:0] C_CNT_ONE  = CNT_BITS'(1);

  generate
    if (FRAME_LEN < 1) begin : g_bad_frame_len
      $error("xor_diff_accum: FRAME_LEN must be at least 1");
    end
    if (((2 ** CNT_W) - 1) < (WIDTH * FRAME_LEN)) begin : g_bad_cnt_w
      $error("xor_diff_accum: CNT_W too narrow for WIDTH*FRAME_LEN");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [CNT_BITS-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0]    acc_dist_q, acc_dist_d;
  logic [WIDTH-1:0]    acc_mask_q, acc_mask_d;
  logic [CNT_W-1:0]    distance_q, distance_d;
  logic [WIDTH-1:0]    or_mask_q,  or_mask_d;
  logic                equal_q,    equal_d;
  logic                done_q,     done_d;

  logic [POP_W-1:0]    pop_cnt;
  logic [CNT_W:0]      dist_sum_wide;
  logic [CNT_W-1:0]    dist_sum;
  logic [WIDTH-1:0]    mask_next;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + POP_W'(diff[i]);
    end
  end

  // One extra bit catches overflow so the accumulator can clamp at all-ones.
  always_comb begin
    dist_sum_wide = {1'b0, acc_dist_q} + {1'b0, CNT_W'(pop_cnt)};
    dist_sum      = dist_sum_wide[CNT_W] ? {CNT_W{1'b1}} : dist_sum_wide[CNT_W-1:0];
    mask_next     = acc_mask_q | diff;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_dist_d = acc_dist_q;
    acc_mask_d = acc_mask_q;
    distance_d = distance_q;
    or_mask_d  = or_mask_q;
    equal_d    = equal_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCUM;
          cnt_d      = '0;
          acc_dist_d = '0;
          acc_mask_d = '0;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          cnt_d      = cnt_q + C_CNT_ONE;
          acc_dist_d = dist_sum;
          acc_mask_d = mask_next;
          // Last word: publish the totals including this word on the same edge.
          if (cnt_q == C_LAST_IDX) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            distance_d = dist_sum;
            or_mask_d  = mask_next;
            equal_d    = (mask_next == '0);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_dist_q <= '0;
      acc_mask_q <= '0;
      distance_q <= '0;
      or_mask_q  <= '0;
      equal_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_dist_q <= acc_dist_d;
      acc_mask_q <= acc_mask_d;
      distance_q <= distance_d;
      or_mask_q  <= or_mask_d;
      equal_q    <= equal_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = (state_q == S_ACCUM);
  assign busy     = (state_q == S_ACCUM);
  assign done     = done_q;
  assign distance = distance_q;
  assign or_mask  = or_mask_q;
  assign equal    = equal_q;

endmodule
`default_nettype wire

// File: tb/tb_xor_diff_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_xor_diff_accum
// Brief    : Directed-vector bench for xor_diff_accum
// Revision : 1.0
// ============================================================================
module tb_xor_diff_accum;

  localparam int WIDTH     = 4;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] diff;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] distance;
  logic [WIDTH-1:0] or_mask;
  logic             equal;

  int n_cmp;
  int n_bad;
  int prev_dist;
  logic [3:0] prev_mask;
  bit prev_eq;

  xor_diff_accum #(
    .WIDTH    (WIDTH),
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_valid(in_valid),
    .diff    (diff),
    .in_ready(in_ready),
    .busy    (busy),
    .done    (done),
    .distance(distance),
    .or_mask (or_mask),
    .equal   (equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 0);
    chk({tag, ".busy"},     32'(busy),     0);
    chk({tag, ".done"},     32'(done),     0);
    chk({tag, ".distance"}, 32'(distance), 0);
    chk({tag, ".or_mask"},  32'(or_mask),  0);
    chk({tag, ".equal"},    32'(equal),    0);
  endtask

  // words[4*i +: 4] is the i-th word of the frame.
  task automatic run_frame(input string tag, input logic [31:0] words, input int stall,
                           input bit poke_start, input int exp_dist,
                           input logic [3:0] exp_mask, input bit exp_eq);
    int busy_cnt;
    busy_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      busy_cnt += int'(busy);
      chk({tag, ".no_early_done"}, 32'(done), 0);
      if (i == 4) begin
        chk({tag, ".hold_dist"}, 32'(distance), 32'(prev_dist));
        chk({tag, ".hold_mask"}, 32'(or_mask),  32'(prev_mask));
        chk({tag, ".hold_eq"},   32'(equal),    32'(prev_eq));
      end
      if (poke_start && i == 3) start = 1'b1;
      in_valid = 1'b1;
      diff     = words[4*i +: 4];
      step();
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < FRAME_LEN - 1) begin
        for (int s = 0; s < stall; s++) begin
          chk({tag, ".stall_ready"}, 32'(in_ready), 1);
          diff = 4'hF;
          step();
        end
      end
    end
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 8);
    chk({tag, ".done"},        32'(done),     1);
    chk({tag, ".busy_in_done"},32'(busy),     0);
    chk({tag, ".ready_in_done"},32'(in_ready),0);
    chk({tag, ".distance"},    32'(distance), 32'(exp_dist));
    chk({tag, ".or_mask"},     32'(or_mask),  32'(exp_mask));
    chk({tag, ".equal"},       32'(equal),    32'(exp_eq));
    if (poke_start) start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ".done_pulse"}, 32'(done), 0);
    chk({tag, ".idle_busy"},  32'(busy), 0);
    step();
    chk({tag, ".stay_idle"},  32'(busy), 0);
    chk({tag, ".held_dist"},  32'(distance), 32'(exp_dist));
    prev_dist = exp_dist;
    prev_mask = exp_mask;
    prev_eq   = exp_eq;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    prev_dist = 0;
    prev_mask = 4'h0;
    prev_eq   = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    diff      = 4'h0;
    #2;
    chk_outputs_zero("por");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk_outputs_zero("after_release");

    run_frame("std",      32'h3333_3333, 0, 1'b0, 16, 4'h3, 1'b0);
    run_frame("zeros",    32'h0000_0000, 0, 1'b0,  0, 4'h0, 1'b1);
    run_frame("ones",     32'hFFFF_FFFF, 0, 1'b0, 32, 4'hF, 1'b0);
    run_frame("stall",    32'h9000_8421, 2, 1'b0,  6, 4'hF, 1'b0);
    run_frame("ign_start",32'h8888_8888, 0, 1'b1,  8, 4'h8, 1'b0);

    // Abort a frame after 5 accepts with an asynchronous mid-cycle reset.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      diff     = 4'h3;
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_rst");
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort.no_done", 32'(done), 0);
    end
    chk_outputs_zero("abort_idle");
    prev_dist = 0;
    prev_mask = 4'h0;
    prev_eq   = 1'b0;
    run_frame("post_rst", 32'h3333_3333, 0, 1'b0, 16, 4'h3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xor_diff_accum.md
# xor_diff_accum

Downstream consumer of the 4-bit XOR stage. It takes a frame of XOR difference words (a ^ b) over a valid/ready handshake and accumulates statistics across the frame:
- Hamming distance (total count of set bits)
- OR-mask of all differing bit positions
- an all-equal flag

When the frame ends it publishes the results with a one-cycle `done` pulse and holds them until the next frame starts.

## Interface
Parameters:
- WIDTH, 4, width of each difference word; must match the XOR stage output width.
- FRAME_LEN, 8, number of words per frame; must be ≥ 1.
- CNT_W, 8, width of the distance accumulator; must satisfy 2^CNT_W − 1 ≥ WIDTH·FRAME_LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new frame; sampled only in IDLE.
- in_valid  in  1  `diff` holds a valid word.
- diff  in  WIDTH  XOR difference word (the XOR stage's `out`).
- in_ready  out  1  block accepts a word this cycle.
- busy  out  1  frame in progress (ACCUM).
- done  out  1  one-cycle pulse when frame results are published.
- distance  out  CNT_W  total popcount of the frame's diff words.
- or_mask  out  WIDTH  bitwise OR of the frame's diff words.
- equal  out  1  1 when every word of the frame was zero.

## Operation
- The FSM has three states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready = 0, busy = 0.
  - If start = 1: go to ACCUM. On the same edge, clear the distance accumulator, the or_mask accumulator and the word counter `cnt`.
  - The published outputs (distance, or_mask, equal) are not cleared by start. They keep the previous frame's results until the next DONE.
- ACCUM:
  - in_ready = 1, busy = 1.
  - A word is accepted on each edge where in_valid & in_ready. On acceptance:
    - acc_dist += popcount(diff), zero-extended to CNT_W.
    - acc_mask |= diff.
    - cnt += 1.
  - When a word is accepted with cnt == FRAME_LEN−1: go to DONE.
  - Cycles with in_valid = 0 are stalls. Nothing changes and there is no timeout.
  - start is ignored in ACCUM.
- DONE:
  - Lasts exactly one cycle. done = 1, in_ready = 0, busy = 0.
  - Next state is unconditionally IDLE. start is ignored in DONE.
- Publication:
  - distance, or_mask and equal are registered and update on the edge that enters DONE.
  - Their values are the final acc_dist, the final acc_mask (including the last word), and equal = (final acc_mask == 0).
  - They hold until the next frame's DONE entry.
- Arithmetic:
  - The distance accumulator saturates at 2^CNT_W − 1. With legal parameters this value is unreachable.
  - cnt width is clog2(FRAME_LEN+1) and cnt never wraps within a frame.
- Reset (asynchronous, any state, including mid-frame):
  - State = IDLE; cnt, acc_dist, acc_mask = 0.
  - distance = 0, or_mask = 0, equal = 0, done = 0.
  - Any partially accumulated frame is discarded.

## Timing
- in_ready and busy are decoded directly from the state register, with no combinational path from in_valid or start.
- done, distance, or_mask and equal come straight from flops.
- Latency: done is asserted in the cycle after the edge that accepted the last word. Results are valid in that same cycle.
- Minimum frame time with in_valid held high: 1 start cycle + FRAME_LEN accept cycles + 1 DONE cycle. With defaults that is 10 cycles from start high to the return to IDLE.
- Back-to-back frames: the earliest next accepted start is the first IDLE cycle after DONE.
- Reset outputs: in_ready = 0, busy = 0, done = 0, distance = 0, or_mask = 0, equal = 0.

## Test plan
- **Reset:** assert rst_n = 0 asynchronously between clock edges → all outputs 0 immediately; state is IDLE after release.
- **Standard frame:** start, then 8 words of diff = 0011 (a = 0101, b = 0110), in_valid held high → done one cycle after the 8th accept; distance = 16, or_mask = 0011, equal = 0; busy high for exactly 8 cycles.
- **Identical operands:** 8 words of diff = 0000 → distance = 0, or_mask = 0000, equal = 1. Then a frame of all 1111 → distance = 32 (the maximum), or_mask = 1111, equal = 0, with no saturation.
- **Stalls and mixed words:** diff sequence 0001, 0010, 0100, 1000, 0000, 0000, 0000, 1001, with in_valid low for 2 cycles between words → distance = 6, or_mask = 1111. Stall cycles leave cnt and the accumulators unchanged.
- **Ignored start:** pulse start during ACCUM (after 3 words) and again in the DONE cycle → frame still completes after 8 total accepts with correct totals; the block returns to IDLE without starting a new frame.
- **Reset mid-frame:** drop rst_n after 5 accepted words, then start a fresh frame of 8 × 0011 → no done from the aborted frame; the new frame reports distance = 16. Published outputs read 0 between the reset and the new DONE.
